// File: rtl/cfg_chain_pkg.sv
// ---------------------------------------------------------------------------
// cfg_chain_pkg
// Shared definitions for the word-wide configuration chain:
//   - FSM state encoding (2-bit, only IDLE and LOAD are used)
//   - header field positions
//   - helpers deriving beat count and chunk width from the node parameters
// ---------------------------------------------------------------------------
package cfg_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1
    } state_t;

    // Target ID occupies the low bits of a header word
    localparam int HDR_ID_LSB = 0;

    // Broadcast flag sits immediately above the target ID
    function automatic int hdr_bcast_bit(input int id_width);
        return id_width;
    endfunction

    // Payload beats needed to cover every cfg bit
    function automatic int calc_num_beats(input int cfg_size, input int word_w);
        return (cfg_size + word_w - 1) / word_w;
    endfunction

    // Bits written to cfg by one commit
    function automatic int calc_chunk_w(input int chunk_beats, input int word_w);
        return chunk_beats * word_w;
    endfunction

endpackage

// File: rtl/cfg_chain_fwd.sv
// ---------------------------------------------------------------------------
// cfg_chain_fwd
// One-stage forward register toward the next node in the chain.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_start/word/valid   beat seen by this node
//   suppress              drop this beat (stream consumed by this node)
//   out_start/word/valid  registered beat for the downstream node
// ---------------------------------------------------------------------------
module cfg_chain_fwd #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_start,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    input  logic              suppress,
    output logic              out_start,
    output logic [WORD_W-1:0] out_word,
    output logic              out_valid
);

    // Suppressed beats leave the chain as an empty cycle with a zero word
    always_ff @(posedge clk) begin
        if (rst) begin
            out_start <= 1'b0;
            out_word  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_start <= in_start && !suppress;
            out_word  <= suppress ? '0 : in_word;
            out_valid <= in_valid && !suppress;
        end
    end

endmodule

// File: rtl/cfg_chain_node.sv
// ---------------------------------------------------------------------------
// cfg_chain_node
// Daisy-chained configuration node. Consumes header-addressed or broadcast
// word streams, stages payload beats and commits them chunk-wise into cfg;
// streams it does not consume exclusively are forwarded with 1-cycle latency.
// Ports:
//   clk, rst                                clock, synchronous active-high reset
//   cfg_in_start/word/valid                 incoming stream (no backpressure)
//   cfg_out_start/word/valid                forwarded stream
//   cfg_commit, cfg_done, cfg_err           1-cycle event pulses
//   cfg_busy                                high while loading
//   cfg                                     configuration bits
// ---------------------------------------------------------------------------
module cfg_chain_node
    import cfg_chain_pkg::*;
#(
    parameter int CFG_SIZE    = 40,
    parameter int WORD_W      = 8,
    parameter int CHUNK_BEATS = 2,
    parameter int ID_WIDTH    = 3,
    parameter int ID          = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_in_start,
    input  logic [WORD_W-1:0]   cfg_in_word,
    input  logic                cfg_in_valid,
    output logic                cfg_out_start,
    output logic [WORD_W-1:0]   cfg_out_word,
    output logic                cfg_out_valid,
    output logic                cfg_commit,
    output logic                cfg_done,
    output logic                cfg_err,
    output logic                cfg_busy,
    output logic [CFG_SIZE-1:0] cfg
);

    localparam int NUM_BEATS = calc_num_beats(CFG_SIZE, WORD_W);
    localparam int CHUNK_W   = calc_chunk_w(CHUNK_BEATS, WORD_W);
    localparam int BCAST_BIT = hdr_bcast_bit(ID_WIDTH);
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [ID_WIDTH-1:0] MY_ID = ID_WIDTH'(ID);

    state_t              state;
    logic [CNT_W-1:0]    beat_cnt;
    logic [CHUNK_W-1:0]  staging;
    logic                bcast;

    logic                hdr_beat;
    logic                data_beat;
    logic                hdr_bcast;
    logic [ID_WIDTH-1:0] hdr_target;
    logic                hdr_match;
    logic                hdr_direct;
    logic                in_load;
    logic                last_beat;
    logic                commit_en;
    logic                suppress;
    logic [CHUNK_W-1:0]  commit_data;
    int                  beat_idx;
    int                  beat_pos;
    int                  chunk_idx;

    // Header decode, beat position and the staging image that includes the
    // current beat. A chunk always lands at the same place in cfg, so beats
    // are placed by their slot in the chunk rather than shifted; this keeps a
    // short final chunk aligned to its low bits.
    always_comb begin
        hdr_beat   = cfg_in_valid && cfg_in_start;
        data_beat  = cfg_in_valid && !cfg_in_start;
        hdr_bcast  = cfg_in_word[BCAST_BIT];
        hdr_target = cfg_in_word[HDR_ID_LSB +: ID_WIDTH];
        hdr_match  = hdr_beat && (hdr_bcast || (hdr_target == MY_ID));
        hdr_direct = hdr_beat && !hdr_bcast && (hdr_target == MY_ID);
        in_load    = (state == ST_LOAD);

        beat_idx   = int'(beat_cnt);
        beat_pos   = beat_idx % CHUNK_BEATS;
        chunk_idx  = beat_idx / CHUNK_BEATS;
        last_beat  = (beat_idx == NUM_BEATS - 1);
        commit_en  = in_load && data_beat &&
                     ((beat_pos == CHUNK_BEATS - 1) || last_beat);

        commit_data = staging;
        for (int p = 0; p < CHUNK_BEATS; p++) begin
            if (p == beat_pos) begin
                commit_data[p*WORD_W +: WORD_W] = cfg_in_word;
            end
        end

        // Header beats decide on themselves; later beats follow the stream
        suppress = hdr_beat ? hdr_direct : (in_load && !bcast);
    end

    // Load FSM: counts payload beats, commits chunks, raises event pulses.
    // A new header during LOAD drops uncommitted beats but keeps cfg, then
    // is decoded as a fresh header on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            staging    <= '0;
            bcast      <= 1'b0;
            cfg        <= '0;
            cfg_commit <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
            cfg_busy   <= 1'b0;
        end else begin
            cfg_commit <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (hdr_beat) begin
                        cfg_err  <= 1'b1;
                        staging  <= '0;
                        beat_cnt <= '0;
                        bcast    <= hdr_bcast;
                        state    <= hdr_match ? ST_LOAD : ST_IDLE;
                        cfg_busy <= hdr_match;
                    end else if (data_beat) begin
                        if (commit_en) begin
                            for (int j = 0; j < CFG_SIZE; j++) begin
                                if ((j / CHUNK_W) == chunk_idx) begin
                                    cfg[j] <= commit_data[j % CHUNK_W];
                                end
                            end
                            cfg_commit <= 1'b1;
                            staging    <= '0;
                        end else begin
                            staging <= commit_data;
                        end
                        if (last_beat) begin
                            cfg_done <= 1'b1;
                            state    <= ST_IDLE;
                            cfg_busy <= 1'b0;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    beat_cnt <= '0;
                    staging  <= '0;
                    if (hdr_match) begin
                        state    <= ST_LOAD;
                        bcast    <= hdr_bcast;
                        cfg_busy <= 1'b1;
                    end else begin
                        state    <= ST_IDLE;
                        cfg_busy <= 1'b0;
                    end
                end
            endcase
        end
    end

    cfg_chain_fwd #(
        .WORD_W (WORD_W)
    ) u_fwd (
        .clk       (clk),
        .rst       (rst),
        .in_start  (cfg_in_start),
        .in_word   (cfg_in_word),
        .in_valid  (cfg_in_valid),
        .suppress  (suppress),
        .out_start (cfg_out_start),
        .out_word  (cfg_out_word),
        .out_valid (cfg_out_valid)
    );

endmodule

// File: tb/tb_cfg_chain_node.sv
// ---------------------------------------------------------------------------
// tb_cfg_chain_node
// Directed streams into a node with ID=2; expected forwarded beats and cfg
// images after each commit are queued by the stimulus and popped by a
// monitor whenever the DUT presents them.
// ---------------------------------------------------------------------------
module tb_cfg_chain_node;

    localparam int CFG_SIZE = 40;
    localparam int WORD_W   = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_in_start = 1'b0;
    logic [WORD_W-1:0]   cfg_in_word = '0;
    logic                cfg_in_valid = 1'b0;
    logic                cfg_out_start;
    logic [WORD_W-1:0]   cfg_out_word;
    logic                cfg_out_valid;
    logic                cfg_commit;
    logic                cfg_done;
    logic                cfg_err;
    logic                cfg_busy;
    logic [CFG_SIZE-1:0] cfg;

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    logic [8:0]          fwd_q[$];
    logic [CFG_SIZE-1:0] cfg_q[$];
    logic [CFG_SIZE-1:0] cfg_model = '0;
    logic                stable_chk = 1'b0;

    always #5 clk = ~clk;

    cfg_chain_node #(
        .CFG_SIZE    (40),
        .WORD_W      (8),
        .CHUNK_BEATS (2),
        .ID_WIDTH    (3),
        .ID          (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_in_start  (cfg_in_start),
        .cfg_in_word   (cfg_in_word),
        .cfg_in_valid  (cfg_in_valid),
        .cfg_out_start (cfg_out_start),
        .cfg_out_word  (cfg_out_word),
        .cfg_out_valid (cfg_out_valid),
        .cfg_commit    (cfg_commit),
        .cfg_done      (cfg_done),
        .cfg_err       (cfg_err),
        .cfg_busy      (cfg_busy),
        .cfg           (cfg)
    );

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one input cycle just after the clock edge
    task automatic applyStimulus(input logic start, input logic [7:0] word,
                                 input logic valid, input logic fwd);
        @(posedge clk);
        #1;
        cfg_in_start = start;
        cfg_in_word  = word;
        cfg_in_valid = valid;
        if (valid && fwd) fwd_q.push_back({start, word});
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Header plus five payload beats, beat i = payload[8i+7:8i]
    task automatic sendStream(input logic [7:0] hdr, input logic [39:0] payload,
                              input logic gaps, input logic fwd,
                              input logic exp_busy);
        applyStimulus(1'b1, hdr, 1'b1, fwd);
        for (int i = 0; i < 5; i++) begin
            if (gaps && i > 0) applyStimulus(1'b0, 8'hFF, 1'b0, 1'b0);
            applyStimulus(1'b0, payload[i*8 +: 8], 1'b1, fwd);
            if (i == 0) checkOutput("busy_after_hdr", cfg_busy, exp_busy);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a beat or commit
    always @(negedge clk) begin
        if (rst) begin
            cfg_model = '0;
        end else begin
            if (cfg_out_valid) begin
                if (fwd_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL fwd_unexpected: got %0h expected none",
                             {cfg_out_start, cfg_out_word});
                end else begin
                    checkOutput("fwd_beat", {cfg_out_start, cfg_out_word},
                                fwd_q.pop_front());
                end
            end
            if (cfg_commit) begin
                if (cfg_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL commit_unexpected: got %0h expected none", cfg);
                end else begin
                    cfg_model = cfg_q.pop_front();
                    checkOutput("commit_cfg", cfg, cfg_model);
                end
            end else if (stable_chk) begin
                checkOutput("cfg_hold", cfg, cfg_model);
            end
            if (cfg_done) done_cnt++;
            if (cfg_err) err_cnt++;
        end
    end

    initial begin
        $display("[TB] start");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_cfg", cfg, 40'h0);
        checkOutput("rst_out_valid", cfg_out_valid, 1'b0);
        checkOutput("rst_busy", cfg_busy, 1'b0);
        checkOutput("rst_pulses", {cfg_commit, cfg_done, cfg_err}, 3'b000);
        rst = 1'b0;

        // Directed write to this node
        cfg_q.push_back(40'h0000002211);
        cfg_q.push_back(40'h0044332211);
        cfg_q.push_back(40'h5544332211);
        sendStream(8'h02, 40'h5544332211, 1'b0, 1'b0, 1'b1);
        idle(3);
        checkOutput("t1_cfg", cfg, 40'h5544332211);
        checkOutput("t1_done", done_cnt, 1);
        checkOutput("t1_busy_end", cfg_busy, 1'b0);

        // Stream for another node passes through untouched
        sendStream(8'h05, 40'hA5A4A3A2A1, 1'b0, 1'b1, 1'b0);
        idle(3);
        checkOutput("t2_cfg", cfg, 40'h5544332211);
        checkOutput("t2_fwd_left", fwd_q.size(), 0);
        checkOutput("t2_done", done_cnt, 1);

        // Broadcast: loaded and forwarded
        cfg_q.push_back(40'h5544336261);
        cfg_q.push_back(40'h5564636261);
        cfg_q.push_back(40'h6564636261);
        sendStream(8'h08, 40'h6564636261, 1'b0, 1'b1, 1'b1);
        idle(3);
        checkOutput("t3_cfg", cfg, 40'h6564636261);
        checkOutput("t3_fwd_left", fwd_q.size(), 0);
        checkOutput("t3_done", done_cnt, 2);

        // Gapped stream; cfg must hold between commits
        cfg_q.push_back(40'h6564632211);
        cfg_q.push_back(40'h6544332211);
        cfg_q.push_back(40'h5544332211);
        stable_chk = 1'b1;
        sendStream(8'h02, 40'h5544332211, 1'b1, 1'b0, 1'b1);
        idle(3);
        stable_chk = 1'b0;
        checkOutput("t4_cfg", cfg, 40'h5544332211);
        checkOutput("t4_commits_left", cfg_q.size(), 0);
        checkOutput("t4_done", done_cnt, 3);

        // Abort: third beat is dropped, first chunk stays
        cfg_q.push_back(40'h554433BBAA);
        applyStimulus(1'b1, 8'h02, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'hAA, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'hBB, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'hCC, 1'b1, 1'b0);
        cfg_q.push_back(40'h5544330101);
        cfg_q.push_back(40'h5501010101);
        cfg_q.push_back(40'h0101010101);
        sendStream(8'h02, 40'h0101010101, 1'b0, 1'b0, 1'b1);
        idle(3);
        checkOutput("t5_err", err_cnt, 1);
        checkOutput("t5_cfg", cfg, 40'h0101010101);
        checkOutput("t5_done", done_cnt, 4);

        // Reset in the middle of a load
        cfg_q.push_back(40'h0101016677);
        applyStimulus(1'b1, 8'h02, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h77, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h66, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h99, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        cfg_in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("t6_rst_cfg", cfg, 40'h0);
        checkOutput("t6_rst_busy", cfg_busy, 1'b0);
        checkOutput("t6_rst_out", {cfg_out_valid, cfg_out_start, cfg_commit, cfg_done, cfg_err}, 5'b0);
        checkOutput("t6_commits_left", cfg_q.size(), 0);
        cfg_q.push_back(40'h0000002211);
        cfg_q.push_back(40'h0044332211);
        cfg_q.push_back(40'h5544332211);
        sendStream(8'h02, 40'h5544332211, 1'b0, 1'b0, 1'b1);
        idle(3);
        checkOutput("t6_cfg", cfg, 40'h5544332211);
        checkOutput("t6_done", done_cnt, 5);
        checkOutput("t6_err", err_cnt, 1);
        checkOutput("end_commits_left", cfg_q.size(), 0);
        checkOutput("end_fwd_left", fwd_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
